// File: rtl/cgol_board_memory.sv
// Double-buffered Game of Life board: a read-only current bank serving neighbour
// fetches and a write-only next bank, exchanged on an accepted swap request.
module cgol_board_memory #(
  parameter int ROWS = 8,
  parameter int COLS = 8,
  parameter int ADDR_W = 6,
  parameter logic [ROWS*COLS-1:0] INIT_PATTERN = 64'h0000_0000_000E_0102
) (
  input  logic                   clk,
  input  logic                   i_reset,
  input  logic [1:0]             i_memory_operation,
  input  logic [ADDR_W-1:0]      i_memory_operation_address,
  input  logic                   i_data,
  output logic                   o_data,
  output logic                   o_data_valid,
  input  logic                   i_swap,
  output logic                   o_swap_done,
  output logic                   o_swap_error,
  output logic                   o_busy,
  output logic [ROWS*COLS-1:0]   o_board,
  output logic                   dbg_state,
  output logic [ADDR_W:0]        dbg_write_count
);

  localparam int CELLS = ROWS * COLS;
  localparam logic [ADDR_W:0] FULL = (ADDR_W + 1)'(CELLS);
  localparam logic [1:0] OP_READ  = 2'b00;
  localparam logic [1:0] OP_WRITE = 2'b01;

  typedef enum logic {
    IDLE = 1'b0,
    SWAP = 1'b1
  } state_t;

  state_t             state;
  state_t             state_next;
  logic [CELLS-1:0]   bank0;
  logic [CELLS-1:0]   bank1;
  logic [CELLS-1:0]   read_bank;
  logic               bank_sel;
  logic [ADDR_W:0]    write_count;
  logic [ADDR_W:0]    count_next;
  logic               is_read;
  logic               is_write;
  logic               swap_reject;

  assign read_bank       = bank_sel ? bank1 : bank0;
  assign o_board         = read_bank;
  assign o_busy          = (state == SWAP);
  assign dbg_state       = state;
  assign dbg_write_count = write_count;

  // Memory operations are only honoured in IDLE; the swap check counts a
  // write issued in the same cycle so the last cell can arrive with i_swap.
  always_comb begin
    state_next  = state;
    is_read     = 1'b0;
    is_write    = 1'b0;
    count_next  = write_count;
    swap_reject = 1'b0;
    case (state)
      IDLE: begin
        is_read  = (i_memory_operation == OP_READ);
        is_write = (i_memory_operation == OP_WRITE);
        if (is_write && (write_count != FULL)) begin
          count_next = write_count + 1'b1;
        end
        if (i_swap) begin
          if (count_next == FULL) begin
            state_next = SWAP;
          end else begin
            swap_reject = 1'b1;
          end
        end
      end
      SWAP: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (i_reset) begin
      state        <= IDLE;
      bank_sel     <= 1'b0;
      bank0        <= INIT_PATTERN;
      bank1        <= '0;
      write_count  <= '0;
      o_data       <= 1'b0;
      o_data_valid <= 1'b0;
      o_swap_done  <= 1'b0;
      o_swap_error <= 1'b0;
    end else begin
      state        <= state_next;
      o_data_valid <= is_read;
      o_swap_done  <= (state == SWAP);
      o_swap_error <= swap_reject;
      if (is_read) begin
        o_data <= read_bank[i_memory_operation_address];
      end
      if (is_write) begin
        if (bank_sel) begin
          bank0[i_memory_operation_address] <= i_data;
        end else begin
          bank1[i_memory_operation_address] <= i_data;
        end
      end
      // The stale write bank becomes the next target; the cell logic refills it completely.
      if (state == SWAP) begin
        bank_sel    <= ~bank_sel;
        write_count <= '0;
      end else begin
        write_count <= count_next;
      end
    end
  end

endmodule
